// File: rtl/jpeg_pkg.sv
// jpeg_pkg: constants shared by the JPEG quantizer / zig-zag serializer.
//   COEF_W, QOUT_W   : default coefficient and quantized-output widths
//   RECIP_W          : width of the fixed-point reciprocals (Q0.16)
//   zz_state_e       : serializer FSM states
//   ZIGZAG_IDX       : zig-zag beat k -> row-major block index
//   QUANT_RECIP_LUMA : ceil(65536 / QUANT_LUMA[i]), row-major
//   QUANT_LUMA       : standard luminance quantization table (quality 50), row-major
package jpeg_pkg;

   localparam int unsigned COEF_W  = 8;
   localparam int unsigned QOUT_W  = 8;
   localparam int unsigned RECIP_W = 16;
   localparam int unsigned BLK_N   = 64;

   typedef enum logic {StIdle, StStream} zz_state_e;

   localparam logic [5:0] ZIGZAG_IDX [0:63] = '{
       0,  1,  8, 16,  9,  2,  3, 10,
      17, 24, 32, 25, 18, 11,  4,  5,
      12, 19, 26, 33, 40, 48, 41, 34,
      27, 20, 13,  6,  7, 14, 21, 28,
      35, 42, 49, 56, 57, 50, 43, 36,
      29, 22, 15, 23, 30, 37, 44, 51,
      58, 59, 52, 45, 38, 31, 39, 46,
      53, 60, 61, 54, 47, 55, 62, 63
   };

   localparam logic [15:0] QUANT_RECIP_LUMA [0:63] = '{
      4096, 5958, 6554, 4096, 2731, 1639, 1286, 1075,
      5462, 5462, 4682, 3450, 2521, 1130, 1093, 1192,
      4682, 5042, 4096, 2731, 1639, 1150,  950, 1171,
      4682, 3856, 2979, 2260, 1286,  754,  820, 1058,
      3641, 2979, 1772, 1171,  964,  602,  637,  852,
      2731, 1873, 1192, 1024,  810,  631,  580,  713,
      1338, 1024,  841,  754,  637,  542,  547,  649,
       911,  713,  690,  669,  586,  656,  637,  662
   };

   localparam logic [7:0] QUANT_LUMA [0:63] = '{
      16,  11,  10,  16,  24,  40,  51,  61,
      12,  12,  14,  19,  26,  58,  60,  55,
      14,  13,  16,  24,  40,  57,  69,  56,
      14,  17,  22,  29,  51,  87,  80,  62,
      18,  22,  37,  56,  68, 109, 103,  77,
      24,  35,  55,  64,  81, 104, 113,  92,
      49,  64,  78,  87, 103, 121, 120, 101,
      72,  92,  95,  98, 112, 100, 103,  99
   };

endpackage

// File: rtl/jpeg_quant_mul.sv
// jpeg_quant_mul: combinational quantizer, q = (coef * recip + rnd) >>> 16.
//   coef_i  : signed CW-bit DCT coefficient
//   recip_i : unsigned 16-bit reciprocal of the quantizer step
//   q_o     : signed OW-bit quantized value
// Build option JPEG_QUANT_ROUND_EN: rnd = 1<<15 (round half up); otherwise rnd = 0 (floor).
module jpeg_quant_mul import jpeg_pkg::*; #(
   parameter int unsigned CW = COEF_W,
   parameter int unsigned OW = QOUT_W
) (
   input  logic [CW-1:0]      coef_i,
   input  logic [RECIP_W-1:0] recip_i,
   output logic [OW-1:0]      q_o
);

   localparam int unsigned PW = CW + RECIP_W;

`ifdef JPEG_QUANT_ROUND_EN
   localparam logic signed [PW-1:0] Rnd = PW'(1 << (RECIP_W - 1));
`else
   localparam logic signed [PW-1:0] Rnd = '0;
`endif

   logic signed [PW-1:0] prod;
   logic signed [PW-1:0] sum;

   always_comb begin
      // Zero-extend the reciprocal so it multiplies as a positive signed value.
      prod = PW'($signed(coef_i)) * PW'($signed({1'b0, recip_i}));
      sum  = prod + Rnd;
      // Smallest step is 10, so the shifted result always fits in OW bits.
      q_o  = OW'(sum >>> RECIP_W);
   end

endmodule

// File: rtl/jpeg_quant_zigzag.sv
// jpeg_quant_zigzag: captures one 8x8 block of signed DCT coefficients, quantizes each
// with the luminance table and streams the results in zig-zag order.
//   clock, reset_n          : clock, asynchronous active-low reset
//   in_valid/in_ready       : block handshake, in_data[0:63] row-major (r*8+c)
//   out_valid/out_ready     : beat handshake; out_data quantized value, out_idx beat k,
//                             out_last on k=63
//   busy                    : high from block acceptance until the last beat transfers
// Build option JPEG_QUANT_ROUND_EN selects round-half-up instead of floor (see jpeg_quant_mul).
module jpeg_quant_zigzag import jpeg_pkg::*; #(
   parameter int unsigned CW = COEF_W,
   parameter int unsigned OW = QOUT_W
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [CW-1:0] in_data [0:63],
   output logic          out_valid,
   input  logic          out_ready,
   output logic [OW-1:0] out_data,
   output logic [5:0]    out_idx,
   output logic          out_last,
   output logic          busy
);

   zz_state_e     state_q, state_d;
   logic [CW-1:0] blk_q [0:63];
   logic [CW-1:0] blk_d [0:63];
   logic [5:0]    k_q, k_d;
   logic          out_valid_q, out_valid_d;
   logic [OW-1:0] out_data_q, out_data_d;
   logic [5:0]    out_idx_q, out_idx_d;
   logic          out_last_q, out_last_d;
   logic          busy_q, busy_d;

   logic [5:0]    src_idx;
   logic [OW-1:0] q_val;

   assign src_idx = ZIGZAG_IDX[k_q];

   jpeg_quant_mul #(
      .CW (CW),
      .OW (OW)
   ) u_mul (
      .coef_i  (blk_q[src_idx]),
      .recip_i (QUANT_RECIP_LUMA[src_idx]),
      .q_o     (q_val)
   );

   always_comb begin
      state_d     = state_q;
      blk_d       = blk_q;
      k_d         = k_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_idx_d   = out_idx_q;
      out_last_d  = out_last_q;
      busy_d      = busy_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               blk_d   = in_data;
               k_d     = '0;
               busy_d  = 1'b1;
               state_d = StStream;
            end
         end
         StStream: begin
            if (out_valid_q && out_ready && out_last_q) begin
               out_valid_d = 1'b0;
               busy_d      = 1'b0;
               state_d     = StIdle;
            end else if (!out_valid_q || out_ready) begin
               // A held last beat (valid && last && !ready) never reaches here.
               out_data_d  = q_val;
               out_idx_d   = k_q;
               out_last_d  = (k_q == 6'd63);
               out_valid_d = 1'b1;
               k_d         = k_q + 6'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         for (int i = 0; i < 64; i++) blk_q[i] <= '0;
         k_q         <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         blk_q       <= blk_d;
         k_q         <= k_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_jpeg_quant_zigzag.sv
// tb_jpeg_quant_zigzag: directed + randomized bench for jpeg_quant_zigzag. Expected beats
// come from a reference built from the quantization formula and a diagonal-walk zig-zag.
module tb_jpeg_quant_zigzag;
   import jpeg_pkg::*;

   typedef logic [7:0] blk_t [0:63];

   logic       clock;
   logic       reset_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data [0:63];
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [5:0] out_idx;
   logic       out_last;
   logic       busy;

   int         n_cmp = 0;
   int         n_err = 0;
   int         zz [0:63];
   logic [7:0] got [0:63];

   jpeg_quant_zigzag dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .busy      (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Q(x) = (x * ceil(65536/QL) + rnd) >>> 16
   function automatic int q_ref(input int x, input int ql);
      int r;
      int rnd;
      r = (65536 + ql - 1) / ql;
`ifdef JPEG_QUANT_ROUND_EN
      rnd = 32768;
`else
      rnd = 0;
`endif
      return (x * r + rnd) >>> 16;
   endfunction

   // Zig-zag order by walking anti-diagonals, alternating direction.
   task automatic build_zz();
      int n = 0;
      for (int s = 0; s < 15; s++) begin
         for (int j = 0; j < 8; j++) begin
            int r;
            int c;
            r = (s % 2 == 0) ? (s - j) : j;
            c = s - r;
            if (r >= 0 && r < 8 && c >= 0 && c < 8 && ((s % 2 == 0) ? (j <= s) : 1'b1)) begin
               zz[n] = r * 8 + c;
               n++;
            end
         end
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, " in_ready"}, in_ready, 1);
      check({tag, " out_valid"}, out_valid, 0);
      check({tag, " busy"}, busy, 0);
   endtask

   // Called at a negedge; returns at the negedge after the acceptance edge.
   task automatic accept_block(input blk_t b, input bit expect_now);
      int w = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (!in_ready && w < 300) begin
         @(negedge clock);
         w++;
      end
      check("accept in_ready", in_ready, 1);
      if (expect_now) check("accept wait", w, 0);
      @(negedge clock);
      check("post-accept busy", busy, 1);
      check("post-accept in_ready", in_ready, 0);
      check("post-accept out_valid", out_valid, 0);
   endtask

   // mode 0: ready high, 1: toggle, 2: random. abort_at >= 0 resets at that beat.
   task automatic stream_block(input blk_t b, input int mode, input blk_t next_b,
                               input bit keep_valid, input int abort_at);
      int exp [0:63];
      int k = 0;
      int cyc = 0;
      int first_valid = -1;
      int rdy_bad = 0;
      bit xfer;
      for (int i = 0; i < 64; i++) exp[i] = q_ref(int'($signed(b[zz[i]])), int'(QUANT_LUMA[zz[i]]));
      if (keep_valid) in_data = next_b;
      in_valid = keep_valid;
      while (k < 64 && cyc < 1000) begin
         if (abort_at >= 0 && k == abort_at && out_valid) begin
            reset_n = 1'b0;
            #1;
            check("abort out_valid", out_valid, 0);
            check("abort in_ready", in_ready, 1);
            check("abort busy", busy, 0);
            check("abort out_idx", out_idx, 0);
            @(negedge clock);
            reset_n = 1'b1;
            @(negedge clock);
            check_idle("after abort");
            return;
         end
         if (in_ready) rdy_bad++;
         if (out_valid) begin
            if (first_valid < 0) first_valid = cyc;
            got[k] = out_data;
            check($sformatf("data k=%0d", k), $signed(out_data), exp[k]);
            check($sformatf("idx k=%0d", k), out_idx, k);
            check($sformatf("last k=%0d", k), out_last, (k == 63));
         end
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         xfer = out_valid && out_ready;
         @(negedge clock);
         cyc++;
         if (xfer) k++;
      end
      check("beats transferred", k, 64);
      check("in_ready during stream", rdy_bad, 0);
      if (mode == 0) begin
         check("first beat latency", first_valid, 1);
         check("cycles to last transfer", cyc, 65);
      end
      check_idle("after last");
   endtask

   blk_t b;
   blk_t b2;

   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < 64; i++) in_data[i] = '0;
      build_zz();
      repeat (2) @(negedge clock);
      check_idle("reset");
      check("reset out_data", out_data, 0);
      check("reset out_idx", out_idx, 0);
      check("reset out_last", out_last, 0);
      reset_n = 1'b1;
      @(negedge clock);
      check_idle("post-reset");

      // All-zero block, full throughput.
      for (int i = 0; i < 64; i++) b[i] = '0;
      accept_block(b, 1'b0);
      stream_block(b, 0, b, 1'b0, -1);

      // DC and zig-zag placement.
      b[0] = 8'd80;
      b[1] = 8'd22;
      b[8] = 8'd24;
      accept_block(b, 1'b0);
      stream_block(b, 0, b, 1'b0, -1);
      check("dc beat0", $signed(got[0]), 5);
      check("dc beat1", $signed(got[1]), 2);
      check("dc beat2", $signed(got[2]), 2);
      check("dc beat3", $signed(got[3]), 0);

      // Same block under toggling backpressure.
      out_ready = 1'b0;
      accept_block(b, 1'b0);
      stream_block(b, 1, b, 1'b0, -1);
      check("bp beat0", $signed(got[0]), 5);
      check("bp beat1", $signed(got[1]), 2);
      check("bp beat2", $signed(got[2]), 2);

      // Negative coefficient: -24/16.
      for (int i = 0; i < 64; i++) b[i] = '0;
      b[0] = 8'hE8;
      accept_block(b, 1'b0);
      stream_block(b, 0, b, 1'b0, -1);
`ifdef JPEG_QUANT_ROUND_EN
      check("neg beat0", $signed(got[0]), -1);
`else
      check("neg beat0", $signed(got[0]), -2);
`endif

      // Back-to-back blocks with in_valid held high.
      for (int i = 0; i < 64; i++) begin
         b[i]  = 8'($urandom);
         b2[i] = 8'($urandom);
      end
      accept_block(b, 1'b0);
      stream_block(b, 0, b2, 1'b1, -1);
      accept_block(b2, 1'b1);
      stream_block(b2, 2, b2, 1'b0, -1);

      // Reset at beat 30, then a fresh block.
      for (int i = 0; i < 64; i++) b[i] = 8'($urandom);
      accept_block(b, 1'b0);
      stream_block(b, 0, b, 1'b0, 30);
      for (int i = 0; i < 64; i++) b[i] = 8'($urandom);
      accept_block(b, 1'b0);
      stream_block(b, 2, b, 1'b0, -1);

      // Random blocks with random backpressure.
      for (int n = 0; n < 3; n++) begin
         for (int i = 0; i < 64; i++) b[i] = 8'($urandom);
         accept_block(b, 1'b0);
         stream_block(b, 2, b, 1'b0, -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
